// File: rtl/display_scanner_pkg.sv
// Shared constants for the seven-segment scanner: state encoding,
// segment bit order and the active-high hex glyph table.
package display_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  // Segment bit positions within the 7-bit segment word.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high glyphs, bit6..bit0 = g f e d c b a; b and d are lowercase.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,  // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,  // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,  // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71   // C d E F
  };

endpackage

// File: rtl/display_scanner_hex_to_seg7.sv
// Combinational nibble to active-high seven-segment decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment driver stepped by each edge of TICK.
// A frame's worth of VALUE/DP/BLANK_LZ is latched into shadow registers
// when digit 0 is entered; all outputs are registered.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  BLANK_LZ,
  output logic [6:0]            SEG,
  output logic                  SEG_DP,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int unsigned   IW   = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic                tick_q;
  logic                step;
  logic                load;
  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       nidx;
  logic [4*DIGITS-1:0] sh_value;
  logic [DIGITS-1:0]   sh_dp;
  logic                sh_blz;
  logic [4*DIGITS-1:0] eff_value;
  logic [DIGITS-1:0]   eff_dp;
  logic                eff_blz;
  logic [3:0]          nib;
  logic [6:0]          seg_raw;
  logic [6:0]          seg_hi;
  logic [DIGITS-1:0]   an_hi;
  logic                dp_hi;
  logic                upper_zero;
  logic                blank;

  // TICK history; deliberately not reset so releasing RST never fakes a step.
  always_ff @(posedge CLK) begin
    tick_q <= TICK;
  end

  // Next digit selection and the data it will display. Outputs are computed
  // from the post-step index and post-load data so they land on the same
  // edge as the step, bypassing the shadow when it is being loaded.
  always_comb begin
    step       = TICK ^ tick_q;
    load       = step && ((state == IDLE) || (idx == LAST));
    nidx       = ((state == IDLE) || (idx == LAST)) ? '0 : idx + 1'b1;
    eff_value  = load ? VALUE    : sh_value;
    eff_dp     = load ? DP       : sh_dp;
    eff_blz    = load ? BLANK_LZ : sh_blz;
    nib        = '0;
    an_hi      = '0;
    dp_hi      = 1'b0;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IW'(i) == nidx) begin
        nib      = eff_value[i*4 +: 4];
        an_hi[i] = 1'b1;
        dp_hi    = eff_dp[i];
      end
      if ((IW'(i) >= nidx) && (eff_value[i*4 +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (seg_raw)
  );

  // Leading-zero blanking: digit 0 is never blanked.
  always_comb begin
    blank  = eff_blz && (nidx != '0) && upper_zero;
    seg_hi = blank ? SEG_OFF : seg_raw;
  end

  // Scan FSM, shadow registers and polarity-adjusted output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blz   <= 1'b0;
      AN       <= {DIGITS{ACTIVE_LOW}};
      SEG      <= {7{ACTIVE_LOW}};
      SEG_DP   <= ACTIVE_LOW;
      FRAME    <= 1'b0;
    end else begin
      FRAME <= 1'b0;
      if (step) begin
        state  <= SHOW;
        idx    <= nidx;
        if (load) begin
          sh_value <= VALUE;
          sh_dp    <= DP;
          sh_blz   <= BLANK_LZ;
        end
        AN     <= an_hi ^ {DIGITS{ACTIVE_LOW}};
        SEG    <= seg_hi ^ {7{ACTIVE_LOW}};
        SEG_DP <= dp_hi ^ ACTIVE_LOW;
        FRAME  <= load;
      end
    end
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed seven-segment display driver that sits directly downstream of the clock `Divider`. It consumes the divider's toggling carry output as its scan-rate reference and steps one digit per toggle. It latches a hex value once per frame, decodes each nibble to segments, optionally blanks leading zeros, and drives common-anode/cathode digit enables.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, range 2..8.
- `ACTIVE_LOW`, default 1: 1 = `SEG`/`SEG_DP`/`AN` asserted low; 0 = asserted high.
- `CLK` input, 1 bit: system clock. Single clock domain.
- `RST` input, 1 bit: reset, synchronous, active-high.
- `TICK` input, 1 bit: divider `CO` toggle. Each edge (rise or fall) is one scan step.
- `VALUE` input, 4*DIGITS bits: hex digits. Nibble i maps to digit i; digit 0 is least significant.
- `DP` input, DIGITS bits: decimal point per digit.
- `BLANK_LZ` input, 1 bit: enables leading-zero blanking.
- `SEG` output, 7 bits: segments; bit0 = a … bit6 = g.
- `SEG_DP` output, 1 bit: decimal-point segment.
- `AN` output, DIGITS bits: digit enables, one-hot when active.
- `FRAME` output, 1 bit: one-cycle pulse when the shadow registers load.

## Operation
- Step detect: `tick_q` <= `TICK` every cycle, including during `RST`. `step` = `TICK` xor `tick_q`. Because `tick_q` tracks during reset, no spurious step occurs at reset release.
- FSM:
  - `IDLE`: the state after reset. All outputs are inactive. On the first `step`: go to `SHOW`, set `idx` = 0, load the shadow.
  - `SHOW`: on `step`, `idx` <= `idx`+1, wrapping from DIGITS-1 to 0. The wrap to 0 loads the shadow.
  - There is no path back to `IDLE` except `RST`.
- Shadow load: `VALUE`, `DP` and `BLANK_LZ` are captured into shadow registers. `FRAME` pulses 1 in the same cycle as the load. The display uses only shadow data, so a mid-frame change of `VALUE` has no visible effect until the next frame.
- Digit `i` is blanked when all of the following hold:
  - shadow `BLANK_LZ` = 1;
  - `i` ≠ 0;
  - shadow nibbles `i`..DIGITS-1 are all 0.
- A blanked digit keeps its `AN` asserted but drives `SEG` all-off. `SEG_DP` still follows shadow `DP[i]`.
- Decoding is standard hex (0-F, lowercase b/d).
- Polarity: every output is generated active-high internally, then XORed with `ACTIVE_LOW` at the output register.
- Reset values:
  - `AN` = all inactive (all 1 when `ACTIVE_LOW`=1).
  - `SEG` = off (7'h7F when `ACTIVE_LOW`=1).
  - `SEG_DP` = off.
  - `FRAME` = 0.
  - `idx` = 0, state = `IDLE`, shadow = 0.

## Timing
- All outputs are registered.
- Latency: `TICK` changes before edge k → `AN`/`SEG`/`SEG_DP`/`FRAME` take their new values at edge k.
- Between steps, outputs are held constant.
- `step` on consecutive cycles is legal: each cycle advances one digit.
- The divider guarantees at most one `TICK` edge per cycle. Multiple edges within a cycle are out of scope.
- `RST` mid-frame takes effect at the next edge: outputs go inactive and state returns to `IDLE`. A `TICK` edge in the same cycle as `RST` is ignored.
- Full frame = DIGITS steps. With the default divider (MODULO = 1e8), each step occurs every MODULO+1 cycles.

## Structure
- Shared package (`display_pkg`):
  - segment-order constants;
  - 16-entry hex-to-segment constant table;
  - `SEG_OFF` constant.
- Sub-module `hex_to_seg7`: combinational nibble → 7-bit active-high segment decoder. Instantiate it once, muxed by `idx`.
- Top module holds:
  - step detector;
  - FSM (`IDLE`/`SHOW`);
  - `idx` counter ($clog2(DIGITS) bits);
  - shadow registers;
  - blanking logic;
  - output registers.

## Test plan
- Reset release with `TICK`=1 held → no step. `AN`=4'b1111, `SEG`=7'h7F, `FRAME`=0, and they stay so until `TICK` toggles.
- `VALUE`=16'h12AF, `BLANK_LZ`=0, four `TICK` toggles:
  - `AN` sequence is 1110, 1101, 1011, 0111;
  - `SEG` is the active-low codes for F, A, 2, 1;
  - `FRAME`=1 only on the first step.
- `VALUE`=16'h0040, `BLANK_LZ`=1 → digits 3 and 2 show `SEG`=7'h7F with `AN` active; digit 1 shows "4"; digit 0 shows "0".
- `VALUE`=16'h0000, `BLANK_LZ`=1 → only digit 0 is lit, showing "0".
- Change `VALUE` from 16'h1111 to 16'h2222 while `idx`=1:
  - digits 2 and 3 still show "1";
  - after the wrap, `FRAME` pulses and all digits show "2".
- `ACTIVE_LOW`=0 build plus `RST` asserted mid-frame at `idx`=2 → next edge: `AN`=0, `SEG`=0, state `IDLE`. The first toggle after release lights digit 0.
